// File: rtl/fetch_align_queue.sv
// Instruction fetch/align front end for the 8080 pipeline: fixed-width fetches fill a
// circular byte queue, and one whole 1/2/3-byte instruction is presented per handshake.
module fetch_align_queue #(
   parameter int              FETCH_BYTES = 2,
   parameter int              DEPTH       = 8,
   parameter int              PC_W        = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     fetch_req,
   output logic [PC_W-1:0]          fetch_addr,
   input  logic                     fetch_valid,
   input  logic [8*FETCH_BYTES-1:0] fetch_data,
   input  logic                     redirect,
   input  logic [PC_W-1:0]          redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [23:0]              out_instr,
   output logic [1:0]               out_len,
   output logic [PC_W-1:0]          out_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [PC_W-1:0] out_pc_q, out_pc_d;

   logic [7:0]      head_b0, head_b1, head_b2;
   logic [1:0]      head_len;
   logic            wr_en, pop;

   function automatic logic [1:0] instr_len(input logic [7:0] op);
      logic [1:0] len;
      casez (op)
         8'b00???110, 8'b11???110, 8'hDB, 8'hD3:                len = 2'd2;
         8'b00??0001, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCB,
         8'hCD, 8'hDD, 8'hED, 8'hFD, 8'b11???010, 8'b11???100:  len = 2'd3;
         default:                                               len = 2'd1;
      endcase
      return len;
   endfunction

   // Bytes not yet in the queue, or beyond the instruction length, read as zero.
   always_comb begin
      head_b0  = (count_q >= CW'(1)) ? mem_q[rd_ptr_q] : 8'h00;
      head_len = instr_len(head_b0);
      head_b1  = (head_len >= 2'd2 && count_q >= CW'(2)) ? mem_q[rd_ptr_q + PW'(1)] : 8'h00;
      head_b2  = (head_len == 2'd3 && count_q >= CW'(3)) ? mem_q[rd_ptr_q + PW'(2)] : 8'h00;
   end

   assign out_valid  = (count_q != '0) && (count_q >= CW'(head_len));
   assign out_instr  = {head_b0, head_b1, head_b2};
   assign out_len    = head_len;
   assign out_pc     = out_pc_q;
   assign fetch_addr = fetch_addr_q;

   // Space check reserves room for the return still in flight; a same-cycle pop is ignored.
   assign fetch_req = !rst && !redirect &&
                      ((int'(count_q) + (inflight_q ? FETCH_BYTES : 0) + FETCH_BYTES) <= DEPTH);

   assign wr_en = fetch_valid && !redirect && !rst;
   assign pop   = out_valid && out_ready && !redirect && !rst;

   always_comb begin
      mem_d        = mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      inflight_d   = fetch_req;
      fetch_addr_d = fetch_addr_q;
      out_pc_d     = out_pc_q;

      if (wr_en) begin
         for (int i = 0; i < FETCH_BYTES; i++) begin
            mem_d[wr_ptr_q + PW'(i)] = fetch_data[8*FETCH_BYTES-8-8*i +: 8];
         end
         wr_ptr_d = wr_ptr_q + PW'(FETCH_BYTES);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(head_len);
         out_pc_d = out_pc_q + PC_W'(head_len);
      end

      count_d = count_q + (wr_en ? CW'(FETCH_BYTES) : CW'(0)) - (pop ? CW'(head_len) : CW'(0));

      if (fetch_req) begin
         fetch_addr_d = fetch_addr_q + PC_W'(FETCH_BYTES);
      end

      // Redirect discards the queue and anything returning this cycle.
      if (redirect) begin
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         inflight_d   = 1'b0;
         fetch_addr_d = redirect_pc;
         out_pc_d     = redirect_pc;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         inflight_q   <= 1'b0;
         fetch_addr_q <= RESET_PC;
         out_pc_q     <= RESET_PC;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         fetch_addr_q <= fetch_addr_d;
         out_pc_q     <= out_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Bench for fetch_align_queue: a memory image serves fetches with one-cycle latency and an
// instruction-stream model (byte queue + PC) predicts every output cycle by cycle.
module tb_fetch_align_queue;

   localparam int          FB       = 2;
   localparam int          DEPTH    = 8;
   localparam int          PC_W     = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic            clk = 1'b0;
   logic            rst;
   logic            fetch_req;
   logic [PC_W-1:0] fetch_addr;
   logic            fetch_valid;
   logic [8*FB-1:0] fetch_data;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [23:0]     out_instr;
   logic [1:0]      out_len;
   logic [PC_W-1:0] out_pc;

   always #5 clk = ~clk;

   fetch_align_queue #(.FETCH_BYTES(FB), .DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_len(out_len), .out_pc(out_pc)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  mem_img [65536];
   logic [7:0]  mq [$];
   logic [15:0] m_fetch_addr, m_pc;
   logic        m_inflight;
   int          since_rst, first_valid;
   logic [15:0] acc_pc [$];
   logic [23:0] acc_instr [$];
   logic [1:0]  acc_len [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction length from the 8080 opcode field rules.
   function automatic int ref_len(input logic [7:0] op);
      int v, hi, lo3;
      v   = int'(op);
      hi  = v / 64;
      lo3 = v % 8;
      if ((hi == 0 || hi == 3) && lo3 == 6) return 2;
      if (v == 'hDB || v == 'hD3) return 2;
      if (hi == 0 && (v % 16) == 1) return 3;
      if (hi == 3 && (lo3 == 2 || lo3 == 4)) return 3;
      if (v == 'h22 || v == 'h2A || v == 'h32 || v == 'h3A || v == 'hC3 || v == 'hCB ||
          v == 'hCD || v == 'hDD || v == 'hED || v == 'hFD) return 3;
      return 1;
   endfunction

   task automatic run_cycle();
      logic        exp_req, exp_valid;
      int          len;
      logic [23:0] exp_instr;
      logic [15:0] ra;
      @(negedge clk);
      exp_req   = !rst && !redirect && ((mq.size() + (m_inflight ? FB : 0) + FB) <= DEPTH);
      len       = (mq.size() > 0) ? ref_len(mq[0]) : 1;
      exp_valid = (mq.size() >= 1) && (mq.size() >= len);
      exp_instr = 24'h0;
      if (exp_valid) begin
         exp_instr[23:16] = mq[0];
         if (len >= 2) exp_instr[15:8] = mq[1];
         if (len == 3) exp_instr[7:0] = mq[2];
      end
      ra = m_fetch_addr;
      check("fetch_req", 32'(fetch_req), 32'(exp_req));
      check("fetch_addr", 32'(fetch_addr), 32'(m_fetch_addr));
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_pc", 32'(out_pc), 32'(m_pc));
      if (exp_valid) begin
         check("out_instr", 32'(out_instr), 32'(exp_instr));
         check("out_len", 32'(out_len), 32'(len));
      end
      if (out_valid && !rst && first_valid < 0) first_valid = since_rst;
      if (out_valid && out_ready && !rst && !redirect) begin
         acc_pc.push_back(out_pc);
         acc_instr.push_back(out_instr);
         acc_len.push_back(out_len);
      end
      @(posedge clk);
      if (rst || redirect) begin
         mq.delete();
         m_inflight   = 1'b0;
         m_pc         = rst ? RESET_PC : redirect_pc;
         m_fetch_addr = m_pc;
      end else begin
         if (exp_valid && out_ready) begin
            repeat (len) void'(mq.pop_front());
            m_pc = m_pc + 16'(len);
         end
         if (fetch_valid) begin
            for (int i = 0; i < FB; i++) mq.push_back(fetch_data[8*(FB-1-i) +: 8]);
         end
         m_inflight = exp_req;
         if (exp_req) m_fetch_addr = m_fetch_addr + 16'(FB);
      end
      since_rst = rst ? 0 : since_rst + 1;
      #1;
      fetch_valid = exp_req;
      fetch_data  = '0;
      if (exp_req) begin
         for (int i = 0; i < FB; i++) begin
            logic [15:0] a;
            a = ra + 16'(i);
            fetch_data[8*(FB-1-i) +: 8] = mem_img[a];
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) run_cycle();
      rst         = 1'b0;
      first_valid = -1;
      acc_pc.delete();
      acc_instr.delete();
      acc_len.delete();
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; fetch_valid = 1'b0;
      fetch_data = '0; out_ready = 1'b1;
      for (int a = 0; a < 65536; a++) mem_img[a] = 8'h00;
      m_pc = RESET_PC; m_fetch_addr = RESET_PC; m_inflight = 1'b0;
      since_rst = 0; first_valid = -1;

      // Reset values and first fetch from all-zero memory.
      rst = 1'b1;
      repeat (2) run_cycle();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fetch_req", 32'(fetch_req), 32'd0);
      check("rst_fetch_addr", 32'(fetch_addr), 32'(RESET_PC));
      check("rst_out_pc", 32'(out_pc), 32'(RESET_PC));
      check("rst_out_len", 32'(out_len), 32'd1);
      check("rst_out_instr", 32'(out_instr), 32'd0);
      do_reset(0);
      repeat (12) run_cycle();
      check("first_valid_cycle", 32'(first_valid), 32'd2);

      // Mixed instruction lengths.
      mem_img[0] = 8'h3E; mem_img[1] = 8'h42; mem_img[2] = 8'hC3;
      mem_img[3] = 8'h34; mem_img[4] = 8'h12; mem_img[5] = 8'h00;
      do_reset(1);
      repeat (12) run_cycle();
      check("mixed_n", 32'(acc_pc.size() >= 3), 32'd1);
      if (acc_pc.size() >= 3) begin
         check("mixed0_instr", 32'(acc_instr[0]), 32'h3E4200);
         check("mixed0_len", 32'(acc_len[0]), 32'd2);
         check("mixed0_pc", 32'(acc_pc[0]), 32'h0000);
         check("mixed1_instr", 32'(acc_instr[1]), 32'hC33412);
         check("mixed1_len", 32'(acc_len[1]), 32'd3);
         check("mixed1_pc", 32'(acc_pc[1]), 32'h0002);
         check("mixed2_instr", 32'(acc_instr[2]), 32'h000000);
         check("mixed2_pc", 32'(acc_pc[2]), 32'h0005);
      end

      // Backpressure: hold decode for 12 cycles, then release.
      out_ready = 1'b0;
      repeat (12) run_cycle();
      check("bp_req_low", 32'(fetch_req), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      repeat (15) run_cycle();

      // Redirect in the same cycle as a return.
      mem_img[16'h0100] = 8'h06; mem_img[16'h0101] = 8'h55;
      mem_img[16'h0102] = 8'h01; mem_img[16'h0103] = 8'hAA; mem_img[16'h0104] = 8'hBB;
      for (int k = 0; k < 10 && !fetch_valid; k++) run_cycle();
      check("redir_has_return", 32'(fetch_valid), 32'd1);
      acc_pc.delete(); acc_instr.delete(); acc_len.delete();
      redirect = 1'b1; redirect_pc = 16'h0100;
      run_cycle();
      redirect = 1'b0;
      check("redir_fetch_addr", 32'(fetch_addr), 32'h0100);
      repeat (10) run_cycle();
      check("redir_n", 32'(acc_pc.size() >= 2), 32'd1);
      if (acc_pc.size() >= 2) begin
         check("redir_pc", 32'(acc_pc[0]), 32'h0100);
         check("redir_instr", 32'(acc_instr[0]), 32'h065500);
         check("redir_instr1", 32'(acc_instr[1]), 32'h01AABB);
      end

      // Partial instruction at the head, then a 3-byte opcode straddling slot 7 -> 0.
      mem_img[0] = 8'hCD; mem_img[1] = 8'h34; mem_img[2] = 8'h12;
      for (int a = 3; a < 7; a++) mem_img[a] = 8'h00;
      mem_img[7] = 8'hCD; mem_img[8] = 8'h78; mem_img[9] = 8'h56;
      do_reset(1);
      repeat (20) run_cycle();
      check("partial_first_valid", 32'(first_valid), 32'd3);
      check("partial_n", 32'(acc_pc.size() >= 6), 32'd1);
      if (acc_pc.size() >= 6) begin
         check("partial_instr", 32'(acc_instr[0]), 32'hCD3412);
         check("straddle_pc", 32'(acc_pc[5]), 32'h0007);
         check("straddle_instr", 32'(acc_instr[5]), 32'hCD7856);
         check("straddle_len", 32'(acc_len[5]), 32'd3);
      end

      // Reset mid-stream with a full queue.
      out_ready = 1'b0;
      repeat (5) run_cycle();
      rst = 1'b1;
      run_cycle();
      rst = 1'b0;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_fetch_addr", 32'(fetch_addr), 32'(RESET_PC));
      out_ready = 1'b1;
      repeat (10) run_cycle();

      // Randomized traffic over a random memory image, including PC wrap.
      for (int a = 0; a < 65536; a++) mem_img[a] = 8'($urandom);
      do_reset(1);
      for (int c = 0; c < 3000; c++) begin
         out_ready = ((c / 100) % 3 == 2) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
         redirect  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 2) == 0) redirect_pc = 16'hFFF8 + 16'($urandom_range(0, 7));
         else redirect_pc = 16'($urandom);
         rst = !redirect && ($urandom_range(0, 299) == 0);
         run_cycle();
      end
      rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
      repeat (5) run_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_align_queue.md
# fetch_align_queue

Parametrised instruction fetch/align front end for the 8080 pipeline. It issues fixed-width fetch requests and buffers the returned bytes in a circular byte queue. It then presents one whole variable-length 8080 instruction (1, 2 or 3 bytes) per handshake to decode, together with its length and PC. It replaces the fixed `pc<=pc+2` fetch and the f1/f2/d valid shift registers. It adds configurable fetch width and depth, backpressure, and redirect/flush.

## Interface
- FETCH_BYTES, 2: bytes per fetch request; legal values 1, 2, 4.
- DEPTH, 8: queue capacity in bytes; power of two, ≥ 2*FETCH_BYTES and ≥ 4.
- PC_W, 16: address width.
- RESET_PC, 0: fetch and instruction PC after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  out  1  request FETCH_BYTES bytes at fetch_addr this cycle.
- fetch_addr  out  PC_W  address of the current request.
- fetch_valid  in  1  fetch_data holds the return for the request issued in the previous cycle.
- fetch_data  in  8*FETCH_BYTES  returned bytes; byte at fetch_addr sits in the MSBs, ascending addresses toward the LSBs.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  new fetch/instruction PC.
- out_valid  out  1  a complete instruction is at the queue head.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  24  opcode [23:16], byte 2 [15:8], byte 3 [7:0]; bytes beyond out_len read as 0.
- out_len  out  2  1, 2 or 3.
- out_pc  out  PC_W  address of the opcode.

## Operation
- **State.** byte array [DEPTH], rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), inflight flag, fetch_addr register, out_pc register.
- **Length decode** is combinational on the head byte.
  - 2 bytes: 00xxx110 (MVI), 11xxx110 (ALU immediates), DB (IN), D3 (OUT).
  - 3 bytes: 00xx0001 (LXI), 22, 2A, 32, 3A, C3, CB, CD, DD, ED, FD, 11xxx010 (Jccc), 11xxx100 (Cccc).
  - All others: 1 byte.
- **fetch_req** = !rst && !redirect && (count + FETCH_BYTES*inflight + FETCH_BYTES ≤ DEPTH). The check is conservative: it ignores a same-cycle pop.
  - On a request: fetch_addr += FETCH_BYTES (modulo 2^PC_W); inflight ← 1.
  - With no request: inflight ← 0.
- **Write.** On fetch_valid && !redirect, the FETCH_BYTES bytes are written at wr_ptr.. in address order; wr_ptr += FETCH_BYTES.
- **Emit.** out_valid = (count ≥ 1) && (count ≥ len(head)). Head bytes are read at rd_ptr, rd_ptr+1, rd_ptr+2 modulo DEPTH.
- **Pop** on out_valid && out_ready: rd_ptr += out_len; out_pc += out_len.
- **Count update:** count ← count + (write ? FETCH_BYTES : 0) − (pop ? out_len : 0). Simultaneous write and pop are legal.
- **Redirect** has the highest priority in its cycle.
  - Any pop and any fetch_valid in that cycle are ignored.
  - Next state: count=0, rd_ptr=wr_ptr=0, inflight=0, fetch_addr=out_pc=redirect_pc.
  - Because fetch_req=0 during the redirect cycle, no stale return can arrive afterwards.
- **Reset** (mid-operation included) forces the same state as a redirect to RESET_PC. fetch_valid during reset is ignored.
- **Wrap-around.** Instructions may straddle the DEPTH−1→0 boundary.
- **PC wrap.** fetch_addr and out_pc wrap modulo 2^PC_W.
- **Partial instruction.** out_valid stays 0 while only part of an instruction is present.

## Timing
- **Reset values:** out_valid=0, fetch_req=0 (held low while rst=1), fetch_addr=RESET_PC, out_pc=RESET_PC, out_len=1, out_instr=0.
- **Registered outputs.** out_valid, out_instr, out_len and out_pc depend only on registered state; there is no combinational path from fetch_data or fetch_valid.
- **Memory latency** is fixed at 1 cycle: a request in cycle N returns with fetch_valid in N+1, and the bytes are visible at the head in N+2.
- **After reset** with rst low from cycle 0: request in cycle 0; the earliest out_valid is cycle 2.
- **After redirect** in cycle R: the first request is in R+1; the earliest out_valid is R+3.
- **Stability.** While out_valid && !out_ready, out_instr, out_len and out_pc hold steady.
- **Throughput.** Up to one instruction per cycle when bytes are available.
- **Backpressure.** count never exceeds DEPTH, and a return is never dropped for lack of space.

## Test plan
- **Reset/first fetch** (FETCH_BYTES=2, memory all 00): fetch_req=1 with fetch_addr 0,2,4… in cycles 0,1,2… → out_valid first in cycle 2 with out_instr=000000, out_len=1, out_pc=0; out_pc then advances by 1 per cycle.
- **Mixed lengths** (bytes 3E 42 C3 34 12 00 from addr 0) → (3E4200, len 2, pc 0), (C33412, len 3, pc 2), (000000, len 1, pc 5).
- **Backpressure** (out_ready=0 for 12 cycles, DEPTH=8) → fetch_req drops once count+reserved would exceed 8; count peaks at 8; outputs stay constant; after release, the byte stream continues with no loss or duplication.
- **Redirect with an in-flight return** (redirect_pc=0x0100 asserted in the cycle fetch_valid returns old data) → old bytes are discarded; fetch_addr=0x0100 in the next cycle; the next accepted out_pc=0x0100.
- **Straddle and partial** (DEPTH=8, a CD opcode lands at rd_ptr=7, its third byte delayed by holding the return) → out_valid=0 until all 3 bytes are present; then out_instr=CDxxyy with bytes read from slots 7, 0, 1.
- **Reset mid-stream** (rst for 1 cycle with count=5 and out_valid=1) → the next cycle shows out_valid=0, fetch_addr=RESET_PC, and refill restarts from RESET_PC.
